aes_key_sched: RTL
==================

Name: aes_key_sched

Overview:
AES-128 round-key generator. It sits directly upstream of the byte-wide AddRoundKey xor slices and drives their w_i inputs.
- Loads a 128-bit cipher key, then produces one round key per advance request, for rounds 0..10.
- Holds the current round key stable on its outputs between advances, so the round controller can step it in lockstep with the state datapath.

Parameters:
NR, 10, number of rounds; fixed for AES-128 (any other value is unsupported).
RCON_INIT, 8'h01, round constant used for the round-1 derivation.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
kld  in  1  load key_in as the round-0 key.
key_in  in  128  cipher key; bits [127:120] are key byte 0.
adv  in  1  step forward to the next round key.
wo_0  out  32  round-key word 0; bits [31:24] map to xor slice for state byte 0.
wo_1  out  32  round-key word 1.
wo_2  out  32  round-key word 2.
wo_3  out  32  round-key word 3.
round  out  4  index of the round key currently presented (0..10).
key_vld  out  1  a loaded key is present.
last  out  1  round == NR.

Behaviour:
- Reset (rst=1 at posedge):
  - wo_0..wo_3 = 0, round = 0, key_vld = 0, last = 0.
  - Internal rcon = RCON_INIT.
  - rst overrides kld and adv.
- Load (kld=1):
  - Next cycle: {wo_0,wo_1,wo_2,wo_3} = key_in, round = 0, rcon = 8'h01, key_vld = 1, last = 0.
  - kld has priority over adv in the same cycle.
  - kld is legal at any time, including mid-schedule; it restarts the schedule.
- Advance (adv=1, kld=0, key_vld=1, round<NR), result visible one cycle later:
  - t = SubWord(RotWord(wo_3)) ^ {rcon,24'h0}.
  - wo_0' = wo_0 ^ t; wo_1' = wo_1 ^ wo_0'; wo_2' = wo_2 ^ wo_1'; wo_3' = wo_3 ^ wo_2'.
  - round += 1; rcon = xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 8'h1b : 0).
- Ignored advances (all state unchanged):
  - adv while key_vld=0.
  - adv while round == NR.
- last: combinational decode of round == NR, qualified by key_vld.
- SubWord: four combinational AES forward S-boxes inside the block (table or composite-field implementation).
- Critical path: one S-box plus a 4-deep xor chain; no multicycle paths.
- Outputs change only on posedge clk.

Optional Feature:
Macro AES_KSCHED_INV_EN.
- Defined:
  - Adds input port adv_dn (1 bit), which steps backward one round when round>0 and key_vld=1.
  - w3p = wo_3 ^ wo_2; w2p = wo_2 ^ wo_1; w1p = wo_1 ^ wo_0.
  - rp = rcon[0] ? ((rcon ^ 9'h11b) >> 1) : (rcon >> 1).
  - w0p = wo_0 ^ SubWord(RotWord(w3p)) ^ {rp,24'h0}.
  - round -= 1; rcon = rp.
  - Priority: rst > kld > adv > adv_dn. adv_dn at round 0 is ignored.
  - Enables decryption after a forward pre-run to round 10.
- Undefined: the adv_dn port does not exist and no inverse logic is synthesised.

Test Plan:
1. Reset, then kld with key_in=2b7e151628aed2a6abf7158809cf4f3c -> next cycle wo_0..3 = 2b7e1516, 28aed2a6, abf71588, 09cf4f3c; round=0; key_vld=1; last=0.
2. One adv after case 1 -> wo = a0fafe17, 88542cb1, 23a33939, 2a6c7605; round=1.
3. Ten consecutive advs after case 1 -> wo = d014f9a8, c9ee2589, e13f0cc8, b6630ca6; round=10; last=1. An 11th adv leaves all outputs unchanged.
4. kld and adv asserted together at round 5 -> reload wins: round=0 and wo equal the new key_in.
5. adv before any kld after reset -> outputs stay 0, key_vld=0. rst asserted mid-schedule (round=4) -> next cycle all outputs 0, round=0.
6. (AES_KSCHED_INV_EN) Ten advs then ten adv_dns -> round-key sequence matches the forward sequence in reverse and ends at 2b7e1516..09cf4f3c with round=0. A further adv_dn is ignored.

Source files
------------

// File: rtl/aes_key_sched.sv
// ---------------------------------------------------------------------------
// aes_key_sched -- AES-128 round-key generator.
//
// Loads a 128-bit cipher key as the round-0 key and then steps forward one
// round key per advance request up to round NR (10). The current round key
// is held stable on wo_0..wo_3 between advances so the round controller can
// step it in lockstep with the state datapath feeding the AddRoundKey slices.
//
// Optional build macro: AES_KSCHED_INV_EN
//   When defined, adds input adv_dn, which steps the schedule back one round
//   (used for decryption after a forward pre-run to round 10).
//
// Ports:
//   clk      in   1    system clock, all state updates on posedge
//   rst      in   1    synchronous active-high reset (overrides kld/adv)
//   kld      in   1    load key_in as the round-0 key (wins over adv)
//   key_in   in   128  cipher key, bits [127:120] are key byte 0
//   adv      in   1    step forward to the next round key
//   adv_dn   in   1    step back one round key (AES_KSCHED_INV_EN only)
//   wo_0..3  out  32   round-key words, wo_0[31:24] feeds state byte 0
//   round    out  4    index of the round key currently presented (0..NR)
//   key_vld  out  1    a loaded key is present
//   last     out  1    round == NR while key_vld
// ---------------------------------------------------------------------------
module aes_key_sched #(
  parameter int         NR        = 10,
  parameter logic [7:0] RCON_INIT = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key_in,
  input  logic         adv,
`ifdef AES_KSCHED_INV_EN
  input  logic         adv_dn,
`endif
  output logic [31:0]  wo_0,
  output logic [31:0]  wo_1,
  output logic [31:0]  wo_2,
  output logic [31:0]  wo_3,
  output logic [3:0]   round,
  output logic         key_vld,
  output logic         last
);

  localparam logic [3:0] NR_L = 4'(NR);

  // AES forward S-box, byte i at bits [2047-8*i -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  // SubWord(RotWord(w)): rotate bytes left by one, then S-box each byte.
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef AES_KSCHED_INV_EN
  // Inverse of xtime: divide by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    logic [8:0] t;
    t = b[0] ? ({1'b0, b} ^ 9'h11b) : {1'b0, b};
    return t[8:1];
  endfunction
`endif

  logic [31:0] w_q [4];
  logic [31:0] w_d [4];
  logic [3:0]  round_q, round_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        vld_q, vld_d;

  logic        at_last;
  logic [31:0] t_fwd;
  logic [31:0] fw0, fw1, fw2, fw3;
`ifdef AES_KSCHED_INV_EN
  logic [7:0]  rcon_prev;
  logic [31:0] bw0, bw1, bw2, bw3;
`endif

  assign at_last = (round_q == NR_L);

  // Forward step: S-box on the last word, then the 4-deep xor ripple.
  assign t_fwd = sub_rot(w_q[3]) ^ {rcon_q, 24'h0};
  assign fw0   = w_q[0] ^ t_fwd;
  assign fw1   = w_q[1] ^ fw0;
  assign fw2   = w_q[2] ^ fw1;
  assign fw3   = w_q[3] ^ fw2;

`ifdef AES_KSCHED_INV_EN
  // Backward step: undo the xor ripple first, then recover word 0 from the
  // previous word 3 and the round constant that produced the current key.
  assign rcon_prev = inv_xtime(rcon_q);
  assign bw3       = w_q[3] ^ w_q[2];
  assign bw2       = w_q[2] ^ w_q[1];
  assign bw1       = w_q[1] ^ w_q[0];
  assign bw0       = w_q[0] ^ sub_rot(bw3) ^ {rcon_prev, 24'h0};
`endif

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_d     = w_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    vld_d   = vld_q;
    if (kld) begin
      w_d[0]  = key_in[127:96];
      w_d[1]  = key_in[95:64];
      w_d[2]  = key_in[63:32];
      w_d[3]  = key_in[31:0];
      round_d = 4'd0;
      rcon_d  = RCON_INIT;
      vld_d   = 1'b1;
    end else if (adv) begin
      // An adv that cannot act still outranks adv_dn in the same cycle.
      if (vld_q && !at_last) begin
        w_d[0]  = fw0;
        w_d[1]  = fw1;
        w_d[2]  = fw2;
        w_d[3]  = fw3;
        round_d = round_q + 4'd1;
        rcon_d  = xtime(rcon_q);
      end
`ifdef AES_KSCHED_INV_EN
    end else if (adv_dn) begin
      if (vld_q && (round_q != 4'd0)) begin
        w_d[0]  = bw0;
        w_d[1]  = bw1;
        w_d[2]  = bw2;
        w_d[3]  = bw3;
        round_d = round_q - 4'd1;
        rcon_d  = rcon_prev;
      end
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) w_q[i] <= 32'h0;
      round_q <= 4'd0;
      rcon_q  <= RCON_INIT;
      vld_q   <= 1'b0;
    end else begin
      w_q     <= w_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      vld_q   <= vld_d;
    end
  end

  assign wo_0    = w_q[0];
  assign wo_1    = w_q[1];
  assign wo_2    = w_q[2];
  assign wo_3    = w_q[3];
  assign round   = round_q;
  assign key_vld = vld_q;
  assign last    = vld_q && at_last;

endmodule
